// File: rtl/unison_readout_counter.sv
// unison_readout_counter
//   Counts rising edges on every digital_unison read-out line over a
//   programmable window. At the end of each window it copies the per-line
//   totals into snapshot registers, which firmware reads over Wishbone.
//
// Ports
//   wb_clk_i, wb_rst_i      sole clock, synchronous active-high reset
//   wbs_*                   Wishbone slave (single-cycle ack, registered data)
//   read_out_I/read_out_Q   asynchronous 2-bit lines per channel; channel c uses [2c+1:2c]
//   irq                     level interrupt, mirrors STATUS.ready
//
// Register map (byte offsets from BASE_ADR)
//   0x00 CTRL   bit0 en (R/W), bit1 clr (write-1 pulse, reads 0)
//   0x04 WINDOW window length in cycles, byte-writable
//   0x08 STATUS bit0 ready, bit1 ovf (sticky, write-1-to-clear)
//   0x0C SNAP_ID 16-bit snapshot sequence number
//   0x40+4k snapshot k = 4*ch + line (I0, I1, Q0, Q1)
module unison_readout_counter #(
   parameter int          NUM_CH   = 6,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_dat_i,
   input  logic [31:0]         wbs_adr_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   input  logic [2*NUM_CH-1:0] read_out_I,
   input  logic [2*NUM_CH-1:0] read_out_Q,
   output logic                irq
);

   localparam int NL = 4 * NUM_CH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating increment: holds at full scale instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
      if (inc && (cnt != CNT_MAX)) return cnt + CNT_W'(1);
      return cnt;
   endfunction

   function automatic logic [31:0] zext(input logic [CNT_W-1:0] cnt);
      logic [31:0] r;
      r = '0;
      r[CNT_W-1:0] = cnt;
      return r;
   endfunction

   // Line k = 4*ch + {I0, I1, Q0, Q1}
   logic [NL-1:0] line_raw;
   always_comb begin
      line_raw = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         line_raw[4*c]     = read_out_I[2*c];
         line_raw[4*c + 1] = read_out_I[2*c + 1];
         line_raw[4*c + 2] = read_out_Q[2*c];
         line_raw[4*c + 3] = read_out_Q[2*c + 1];
      end
   end

   logic [NL-1:0] sync_p0, sync_p1, prev_p2, edge_p3;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         prev_p2 <= '0;
         edge_p3 <= '0;
      end else begin
         // p0/p1: two-flop synchronizer
         sync_p0 <= line_raw;
         sync_p1 <= sync_p0;
         // p2: previous synchronized value
         prev_p2 <= sync_p1;
         // p3: registered rising-edge pulse, feeds the live counters
         edge_p3 <= sync_p1 & ~prev_p2;
      end
   end

   // Wishbone decode
   logic       req, acc;
   logic [5:0] word, snap_idx;
   logic       hit_ctrl, hit_window, hit_status, hit_snapid, hit_snap;
   logic       wr_ctrl, wr_window, wr_status;
   logic       adr_unused;

   assign req        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign acc        = req & ~wbs_ack_o;
   assign word       = wbs_adr_i[7:2];
   assign snap_idx   = word - 6'd16;
   assign adr_unused = ^wbs_adr_i[1:0];
   assign hit_ctrl   = (word == 6'd0);
   assign hit_window = (word == 6'd1);
   assign hit_status = (word == 6'd2);
   assign hit_snapid = (word == 6'd3);
   assign hit_snap   = (word >= 6'd16) && ({1'b0, snap_idx} < 7'(NL));
   assign wr_ctrl    = acc & wbs_we_i & hit_ctrl & wbs_sel_i[0];
   assign wr_window  = acc & wbs_we_i & hit_window;
   assign wr_status  = acc & wbs_we_i & hit_status & wbs_sel_i[0];

   logic             en, clr_p, ready, ovf;
   logic [31:0]      window, timer;
   logic [15:0]      snap_id;
   logic [CNT_W-1:0] live [NL];
   logic [CNT_W-1:0] snap [NL];
   logic             win_end, sat_hit;
   logic [31:0]      rdata;

   // A pending clr pulse suppresses the window end that would coincide with it.
   assign win_end = en && (window != 32'd0) && (timer == window - 32'd1) && !clr_p;
   assign irq     = ready;

   always_comb begin
      sat_hit = 1'b0;
      if (en && !clr_p) begin
         for (int k = 0; k < NL; k++) begin
            if (edge_p3[k] && (live[k] == CNT_MAX)) sat_hit = 1'b1;
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (hit_ctrl)   rdata = {31'd0, en};
      if (hit_window) rdata = window;
      if (hit_status) rdata = {30'd0, ovf, ready};
      if (hit_snapid) rdata = {16'd0, snap_id};
      for (int k = 0; k < NL; k++) begin
         if (hit_snap && (snap_idx == 6'(k))) rdata = zext(snap[k]);
      end
   end

   // Control, status and bus response
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         en        <= 1'b0;
         clr_p     <= 1'b0;
         window    <= '0;
         ready     <= 1'b0;
         ovf       <= 1'b0;
         snap_id   <= '0;
      end else begin
         wbs_ack_o <= acc;
         wbs_dat_o <= acc ? rdata : 32'd0;
         clr_p     <= wr_ctrl & wbs_dat_i[1];
         if (wr_ctrl) en <= wbs_dat_i[0];
         if (wr_window) begin
            for (int b = 0; b < 4; b++) begin
               if (wbs_sel_i[b]) window[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
         end
         // Clears first so that a hardware set in the same cycle wins.
         if (wr_status && wbs_dat_i[0]) ready <= 1'b0;
         if (wr_status && wbs_dat_i[1]) ovf   <= 1'b0;
         if (win_end) begin
            ready   <= 1'b1;
            snap_id <= snap_id + 16'd1;
         end
         if (sat_hit) ovf <= 1'b1;
      end
   end

   // Live counters, window timer and snapshots
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timer <= '0;
         for (int k = 0; k < NL; k++) begin
            live[k] <= '0;
            snap[k] <= '0;
         end
      end else if (clr_p) begin
         // Any edge arriving in this cycle is dropped along with the counts.
         timer <= '0;
         for (int k = 0; k < NL; k++) live[k] <= '0;
      end else if (en) begin
         if (win_end) begin
            // The edge of the final cycle still belongs to the closing window.
            timer <= '0;
            for (int k = 0; k < NL; k++) begin
               snap[k] <= sat_inc(live[k], edge_p3[k]);
               live[k] <= '0;
            end
         end else begin
            if (window != 32'd0) timer <= timer + 32'd1;
            for (int k = 0; k < NL; k++) live[k] <= sat_inc(live[k], edge_p3[k]);
         end
      end
   end

endmodule

// File: tb/tb_unison_readout_counter.sv
// Self-checking bench for unison_readout_counter (NUM_CH=6, CNT_W=4).
// Pulses are generated per line and the expected snapshot is simply the
// number of pulses driven in the window, clipped at 15.
module tb_unison_readout_counter;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_WIN  = BASE + 32'h04;
   localparam logic [31:0] A_STAT = BASE + 32'h08;
   localparam logic [31:0] A_ID   = BASE + 32'h0C;
   localparam int NL = 24;

   logic        clk, rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] dat_w, adr, dat_r;
   logic        ack, irq;
   logic [11:0] ri, rq;

   int checks, errors;
   int pc [NL];
   int exp_snap [NL];
   int exp_id;

   unison_readout_counter #(.NUM_CH(6), .CNT_W(4), .BASE_ADR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
      .read_out_I(ri), .read_out_Q(rq), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] snap_adr(input int k);
      return BASE + 32'h40 + 32'(4 * k);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s; lat = -1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            lat = i;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; lat = -1;
      d = 32'hDEAD_BEEF;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            lat = i;
            d = dat_r;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic set_line(input int k, input logic v);
      int c;
      c = k / 4;
      case (k % 4)
         0:       ri[2*c]     = v;
         1:       ri[2*c + 1] = v;
         2:       rq[2*c]     = v;
         default: rq[2*c + 1] = v;
      endcase
   endtask

   // All lines pulse in parallel, 4 cycles high / 4 low; line k pulses pc[k] times.
   task automatic drive_pulses();
      int mx;
      mx = 0;
      for (int k = 0; k < NL; k++) if (pc[k] > mx) mx = pc[k];
      for (int s = 0; s < mx; s++) begin
         for (int k = 0; k < NL; k++) if (pc[k] > s) set_line(k, 1'b1);
         tick(4);
         for (int k = 0; k < NL; k++) set_line(k, 1'b0);
         tick(4);
      end
   endtask

   task automatic clear_pc();
      for (int k = 0; k < NL; k++) pc[k] = 0;
   endtask

   // Expected snapshot after a window in which pc[] pulses were driven.
   task automatic model_window();
      for (int k = 0; k < NL; k++) exp_snap[k] = (pc[k] > 15) ? 15 : pc[k];
      exp_id = exp_id + 1;
   endtask

   // Fresh window: stop, clear status, set length, enable with clr, pulse,
   // wait for the window to close, then stop again. n = cycles waited for irq.
   task automatic run_window(input int w, output int n);
      int lat;
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      wb_write(A_STAT, 32'h3, 4'h1, lat);
      wb_write(A_WIN, 32'(w), 4'hF, lat);
      wb_write(A_CTRL, 32'h3, 4'h1, lat);
      tick(2);
      drive_pulses();
      n = -1;
      for (int i = 0; i < 2000; i++) begin
         if (irq) begin
            n = i;
            break;
         end
         tick(1);
      end
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat;
      logic [31:0] regs [4];
      regs[0] = A_CTRL; regs[1] = A_WIN; regs[2] = A_STAT; regs[3] = A_ID;
      rst = 1'b1;
      tick(3);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
      checks++; if (dat_r !== 32'd0) begin errors++; $display("FAIL reset_dat got %h want 0", dat_r); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
      rst = 1'b0;
      tick(1);
      for (int i = 0; i < 4 + NL; i++) begin
         logic [31:0] a;
         a = (i < 4) ? regs[i] : snap_adr(i - 4);
         tick(1);
         wb_read(a, d, lat);
         checks++;
         if (d !== 32'd0) begin errors++; $display("FAIL reset_read adr %h got %h want 0", a, d); end
         checks++;
         if (lat != 1) begin errors++; $display("FAIL reset_ack_latency adr %h got %0d want 1", a, lat); end
      end
   endtask

   task automatic test_window_reg();
      logic [31:0] d, r1, r2, e;
      logic [3:0] s;
      int lat;
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      r1 = $urandom;
      wb_write(A_WIN, r1, 4'hF, lat);
      wb_read(A_WIN, d, lat);
      checks++; if (d !== r1) begin errors++; $display("FAIL window_full got %h want %h", d, r1); end
      r2 = $urandom;
      s = 4'($urandom_range(0, 15));
      wb_write(A_WIN, r2, s, lat);
      for (int b = 0; b < 4; b++) e[8*b +: 8] = s[b] ? r2[8*b +: 8] : r1[8*b +: 8];
      wb_read(A_WIN, d, lat);
      checks++; if (d !== e) begin errors++; $display("FAIL window_bytes sel %h got %h want %h", s, d, e); end
      wb_write(A_WIN, 32'h0, 4'hF, lat);
      wb_write(A_CTRL, 32'h1, 4'h0, lat);
      wb_read(A_CTRL, d, lat);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_sel0 got %h want 0", d); end
      wb_write(A_CTRL, 32'h2, 4'h1, lat);
      wb_read(A_CTRL, d, lat);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_clr_reads0 got %h want 0", d); end
      wb_write(A_CTRL, 32'h1, 4'h1, lat);
      wb_read(A_CTRL, d, lat);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_en got %h want 1", d); end
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
   endtask

   task automatic test_single_line();
      logic [31:0] d;
      int lat, n;
      clear_pc();
      pc[11] = 7;
      run_window(100, n);
      checks++; if (n < 0) begin errors++; $display("FAIL single_irq_timeout got %0d want >=0", n); end
      model_window();
      for (int k = 0; k < NL; k++) begin
         wb_read(snap_adr(k), d, lat);
         checks++;
         if (d !== 32'(exp_snap[k])) begin errors++; $display("FAIL single_snap%0d got %0d want %0d", k, d, exp_snap[k]); end
      end
      wb_read(A_STAT, d, lat);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL single_status got %h want 1", d); end
      wb_read(A_ID, d, lat);
      checks++; if (d !== 32'(exp_id & 16'hFFFF)) begin errors++; $display("FAIL single_snapid got %0d want %0d", d, exp_id); end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      int lat, n;
      clear_pc();
      pc[5] = 20;
      run_window(250, n);
      checks++; if (n < 0) begin errors++; $display("FAIL sat_irq_timeout got %0d want >=0", n); end
      model_window();
      wb_read(snap_adr(5), d, lat);
      checks++; if (d !== 32'd15) begin errors++; $display("FAIL sat_snap got %0d want 15", d); end
      wb_read(A_STAT, d, lat);
      checks++; if (d !== 32'h3) begin errors++; $display("FAIL sat_status got %h want 3", d); end
      wb_write(A_STAT, 32'h2, 4'h1, lat);
      wb_read(A_STAT, d, lat);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL sat_ovf_w1c got %h want 1", d); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int lat, n;
      logic ovf_exp;
      for (int it = 0; it < 3; it++) begin
         ovf_exp = 1'b0;
         for (int k = 0; k < NL; k++) begin
            pc[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 6);
            if (pc[k] > 15) ovf_exp = 1'b1;
         end
         run_window(300, n);
         checks++; if (n < 0) begin errors++; $display("FAIL rand%0d_irq_timeout got %0d want >=0", it, n); end
         model_window();
         for (int k = 0; k < NL; k++) begin
            wb_read(snap_adr(k), d, lat);
            checks++;
            if (d !== 32'(exp_snap[k])) begin errors++; $display("FAIL rand%0d_snap%0d got %0d want %0d", it, k, d, exp_snap[k]); end
         end
         wb_read(A_STAT, d, lat);
         checks++; if (d !== {30'd0, ovf_exp, 1'b1}) begin errors++; $display("FAIL rand%0d_status got %h want %h", it, d, {30'd0, ovf_exp, 1'b1}); end
         wb_read(A_ID, d, lat);
         checks++; if (d !== 32'(exp_id & 16'hFFFF)) begin errors++; $display("FAIL rand%0d_snapid got %0d want %0d", it, d, exp_id); end
         wb_write(A_STAT, 32'h3, 4'h1, lat);
         wb_read(A_STAT, d, lat);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL rand%0d_status_clr got %h want 0", it, d); end
      end
   endtask

   task automatic test_clr_vs_window();
      localparam int W = 120;
      logic [31:0] d;
      int lat, n;
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      wb_write(A_STAT, 32'h3, 4'h1, lat);
      wb_write(A_WIN, 32'(W), 4'hF, lat);
      wb_read(A_ID, d, lat);
      checks++; if (d !== 32'(exp_id & 16'hFFFF)) begin errors++; $display("FAIL clrwin_id_before got %0d want %0d", d, exp_id); end
      // Enable with clr: the timer restarts from 0 one cycle after this ack.
      wb_write(A_CTRL, 32'h3, 4'h1, lat);
      clear_pc();
      pc[0] = 3;
      drive_pulses();
      tick(W - 1 - 24);
      // This clr is accepted on the cycle the timer reaches W-1.
      wb_write(A_CTRL, 32'h3, 4'h1, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL clrwin_write_latency got %0d want 1", lat); end
      tick(2);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clrwin_no_snapshot irq got %b want 0", irq); end
      n = -1;
      for (int i = 1; i <= 300; i++) begin
         tick(1);
         if (irq) begin
            n = i;
            break;
         end
      end
      checks++; if (n != W - 1) begin errors++; $display("FAIL clrwin_next_window got %0d want %0d", n, W - 1); end
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      clear_pc();
      model_window();
      wb_read(A_ID, d, lat);
      checks++; if (d !== 32'(exp_id & 16'hFFFF)) begin errors++; $display("FAIL clrwin_id_after got %0d want %0d", d, exp_id); end
      wb_read(snap_adr(0), d, lat);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL clrwin_live_cleared got %0d want 0", d); end
   endtask

   task automatic test_disable();
      logic [31:0] d;
      int lat, n, k;
      k = $urandom_range(0, NL - 1);
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      wb_write(A_STAT, 32'h3, 4'h1, lat);
      wb_write(A_WIN, 32'd400, 4'hF, lat);
      wb_write(A_CTRL, 32'h3, 4'h1, lat);
      tick(2);
      clear_pc(); pc[k] = 3; drive_pulses();
      tick(2);
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      clear_pc(); pc[k] = 5; drive_pulses();
      tick(10);
      wb_write(A_CTRL, 32'h1, 4'h1, lat);
      tick(2);
      clear_pc(); pc[k] = 2; drive_pulses();
      n = -1;
      for (int i = 0; i < 1000; i++) begin
         if (irq) begin
            n = i;
            break;
         end
         tick(1);
      end
      checks++; if (n < 0) begin errors++; $display("FAIL dis_irq_timeout got %0d want >=0", n); end
      wb_write(A_CTRL, 32'h0, 4'h1, lat);
      clear_pc(); pc[k] = 5;
      model_window();
      for (int j = 0; j < NL; j++) begin
         wb_read(snap_adr(j), d, lat);
         checks++;
         if (d !== 32'(exp_snap[j])) begin errors++; $display("FAIL dis_snap%0d got %0d want %0d", j, d, exp_snap[j]); end
      end
      wb_read(A_ID, d, lat);
      checks++; if (d !== 32'(exp_id & 16'hFFFF)) begin errors++; $display("FAIL dis_snapid got %0d want %0d", d, exp_id); end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      int lat;
      wb_read(BASE + 32'h100, d, lat);
      checks++; if (lat != -1) begin errors++; $display("FAIL decode_out_of_range ack latency got %0d want none", lat); end
      tick(1);
      wb_read(BASE + 32'h20, d, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL decode_hole_ack got %0d want 1", lat); end
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL decode_hole_data got %h want 0", d); end
      wb_read(snap_adr(NL), d, lat);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL decode_snap_beyond got %h want 0", d); end
      wb_write(snap_adr(11), 32'hFFFF_FFFF, 4'hF, lat);
      wb_write(snap_adr(5), 32'hFFFF_FFFF, 4'hF, lat);
      wb_read(snap_adr(11), d, lat);
      checks++; if (d !== 32'(exp_snap[11])) begin errors++; $display("FAIL decode_snap_ro11 got %h want %0d", d, exp_snap[11]); end
      wb_read(snap_adr(5), d, lat);
      checks++; if (d !== 32'(exp_snap[5])) begin errors++; $display("FAIL decode_snap_ro5 got %h want %0d", d, exp_snap[5]); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int lat, n;
      clear_pc();
      pc[3] = 2;
      run_window(50, n);
      model_window();
      wb_read(snap_adr(3), d, lat);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL rstmid_snap_before got %0d want 2", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid_irq_before got %b want 1", irq); end
      rst = 1'b1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
      tick(1);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b want 0", ack); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %b want 0", irq); end
      rst = 1'b0;
      cyc = 1'b0; stb = 1'b0;
      tick(1);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_inflight_ack got %b want 0", ack); end
      wb_read(A_ID, d, lat);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_snapid got %0d want 0", d); end
      wb_read(A_WIN, d, lat);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_window got %0d want 0", d); end
      wb_read(snap_adr(3), d, lat);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_snap got %0d want 0", d); end
   endtask

   initial begin
      checks = 0; errors = 0; exp_id = 0;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      dat_w = '0; adr = '0; ri = '0; rq = '0;
      for (int k = 0; k < NL; k++) begin
         pc[k] = 0;
         exp_snap[k] = 0;
      end
      test_reset();
      test_window_reg();
      test_single_line();
      test_saturation();
      test_random();
      test_clr_vs_window();
      test_disable();
      test_decode();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unison_readout_counter.md
# unison_readout_counter

Wishbone-mapped event counter for the cochlea readout path. It sits downstream of the `digital_unison` channel cores. It takes each core's 2-bit `read_out_I` and 2-bit `read_out_Q` lines, which are asynchronous to the Wishbone clock. It counts rising edges per line over a programmable window and latches the per-window totals into snapshot registers that firmware reads over Wishbone, so the chip no longer needs logic-analyzer polling.

## Interface
Parameters:
- `NUM_CH`, default 6: number of `digital_unison` channels; each channel has 4 lines (I0, I1, Q0, Q1).
- `CNT_W`, default 16: counter width, 1..32.
- `BASE_ADR`, default 32'h3000_0000: block base address. Bits [31:8] are decoded.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `read_out_I`  in  2*NUM_CH  channel c uses bits [2c+1:2c]; asynchronous.
- `read_out_Q`  in  2*NUM_CH  channel c uses bits [2c+1:2c]; asynchronous.
- `irq`  out  1  level interrupt, equal to STATUS.ready.

## Operation
Register map (offsets from BASE_ADR):
- 0x00 CTRL: bit0 `en` (R/W); bit1 `clr` (write-1 pulse, reads 0). Only byte 0 is used.
- 0x04 WINDOW: 32-bit window length in cycles (R/W); honours `wbs_sel_i` per byte.
- 0x08 STATUS: bit0 `ready`, bit1 `ovf`. Both are sticky; writing 1 clears the bit.
- 0x0C SNAP_ID: 16-bit snapshot sequence number, read-only; wraps 0xFFFF -> 0.
- 0x40 + 4k: snapshot counter k (read-only, zero-extended), where k = 4*ch + line and line order is I0, I1, Q0, Q1. Valid for k < 4*NUM_CH.
- Any other in-range offset is acked; reads return 0 and writes are ignored.

Input path:
- Each line passes through a 2-flop synchronizer, then a previous-value register.
- A rising edge is synchronized high while the previous value is low.
- Edges detected while `en`=0 are discarded.

Live counters:
- One live counter per line, incremented by 1 per detected edge while `en`=1.
- Counters saturate at 2^CNT_W-1. A saturation attempt sets `ovf`.

Window timer:
- Runs while `en`=1 and WINDOW≠0.
- On the cycle the timer equals WINDOW-1:
  - all live counts, including any edge detected in that cycle, are copied to the snapshots;
  - live counters and timer go to 0;
  - `ready` is set and SNAP_ID increments.
- WINDOW=0 means the timer holds at 0 and no snapshots are taken.
- A WINDOW write does not reset the timer. If the timer is already ≥ the new WINDOW, it runs on, wraps through 2^32-1, and ends the window when it reaches WINDOW-1.

Clear and enable:
- `clr` zeroes the live counters and timer in the cycle after the write is acked.
- `clr` does not touch snapshots, STATUS or SNAP_ID.
- `en`=0 freezes the live counters and timer; they are not cleared.

Simultaneous events:
- `clr` pulse and window end in the same cycle: `clr` wins, and no snapshot is taken.
- W1C write to `ready`/`ovf` and hardware set in the same cycle: the set wins.
- Edge and `clr` in the same cycle: the edge is lost.

Wishbone:
- A request is `wbs_cyc_i` & `wbs_stb_i` with `wbs_adr_i`[31:8]==BASE_ADR[31:8].
- `wbs_ack_o` is a 1-cycle pulse, asserted the cycle after a request is seen while `wbs_ack_o` is low. There is no wait state beyond that.
- `wbs_dat_o` is registered alongside `wbs_ack_o` and holds 0 when `wbs_ack_o` is low.
- Write side effects take effect on the ack cycle.
- Out-of-range addresses get no ack.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0.
- Reset clears all registers: CTRL, WINDOW, STATUS, SNAP_ID, timer, counters, snapshots and synchronizers.
- Input latency: a line rising before clock edge t is counted in the live counter at edge t+3 (assuming `en`=1).
- Minimum countable pulse: high ≥2 cycles and low ≥2 cycles.
- Read/write latency: request at edge t gives ack and data at t+1. The read returns register contents as of edge t, so a snapshot updating at t is not visible in that read.
- `irq` follows `ready` with 0-cycle delay, since it is a direct register output.
- Reset asserted mid-operation or mid-transaction returns the block to reset values on the next edge. An in-flight request is not acked.

## Test plan
- Reset, then read every register -> all read 0; `irq`=0; each read acked exactly 1 cycle after the request.
- WINDOW=100, `en`=1; drive 7 clean pulses (4 high/4 low) on channel 2 Q1 -> snapshot k=11 reads 7, all others read 0; `ready`=1, SNAP_ID=1.
- Counter saturation (CNT_W=4): 20 pulses on one line within a window -> snapshot reads 15, `ovf`=1. Writing 0x2 to STATUS clears `ovf` only.
- Clear vs window end: time the `clr` write so it lands on the window-end cycle -> no snapshot taken, SNAP_ID unchanged, live counters and timer 0.
- Mid-window disable/enable: 3 pulses, `en`=0 for 50 cycles with 5 pulses, then `en`=1 and 2 pulses -> snapshot reads 5.
- Address decode: access with adr[31:8] ≠ base -> no ack. Read of in-range offset 0x20 -> ack, data 0. Write to a snapshot register -> value unchanged.
